fft_addr_seq: RTL and testbench
===============================

FFT_ADDR_SEQ -- requirements
Module: fft_addr_seq

Interface
REQ-001 Parameter LOGN, default 8, log2 of FFT length N = 2^LOGN; legal range 2..10.
REQ-002 Clk  input  1  the only clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-low; sampled on rising Clk.
REQ-004 Start  input  1  request a transform; sampled only in INIT.
REQ-005 Ack  input  1  acknowledge completion; sampled only in DONE.
REQ-006 Stall  input  1  freeze the butterfly sequence while high in PROC.
REQ-007 Inverse  input  1  transform direction; latched at accepted Start.
REQ-008 i_top  output  LOGN  top butterfly operand index.
REQ-009 i_bot  output  LOGN  bottom butterfly operand index.
REQ-010 address  output  LOGN-1  twiddle ROM index, W_N^address.
REQ-011 Valid  output  1  i_top/i_bot/address describe a butterfly to be written this edge.
REQ-012 tw_conj  output  1  latched Inverse; consumer conjugates twiddle when high.
REQ-013 stage  output  4  current stage number s, 0..LOGN-1.
REQ-014 Done  output  1  high while in DONE.
REQ-015 state  output  4  FSM encoding: INIT=4'd0, DONE=4'd1, PROC=4'd2.

Function
REQ-016 Internal registers: stage s (4 bit), butterfly count k (LOGN-1 bit), FSM state, tw_conj.
REQ-017 i_top, i_bot, address are combinational from registered s, k, so a consumer writes results at the same edge Valid is high.
REQ-018 half = 2^s; pos = k mod half; grp = k / half; i_top = grp*2*half + pos; i_bot = i_top + half.
REQ-019 address = pos * 2^(LOGN-1-s), truncated to LOGN-1 bits.
REQ-020 Order is radix-2 in-place DIT; operand data is loaded in bit-reversed order by the consumer.
REQ-021 INIT: Start=1 -> PROC with s=0, k=0, tw_conj<=Inverse; otherwise stay.
REQ-022 PROC: Valid = ~Stall; state is always PROC (4'd2), including stalled cycles.
REQ-023 PROC, Stall=0, k<N/2-1: k<=k+1.
REQ-024 PROC, Stall=0, k=N/2-1, s<LOGN-1: k<=0, s<=s+1 (wrap, no gap cycle).
REQ-025 PROC, Stall=0, k=N/2-1, s=LOGN-1: -> DONE; that cycle still has Valid=1.
REQ-026 PROC, Stall=1: s, k, state held; outputs unchanged; Valid=0.
REQ-027 Unstalled transform is exactly (N/2)*LOGN Valid cycles; the first Valid cycle is the one immediately after the Start edge.
REQ-028 Start and Inverse are ignored in PROC and DONE; tw_conj is constant for a whole transform.
REQ-029 DONE: Done=1, Valid=0; Ack=1 -> INIT; Start is ignored, including when Start and Ack are both high.
REQ-030 DONE -> INIT -> PROC requires a fresh Start sampled in INIT; a held Start re-triggers one cycle after leaving DONE.
REQ-031 In INIT and DONE, i_top, i_bot, address show the s, k values held; Valid=0.

Reset
REQ-032 Reset=0 at an edge forces INIT, s=0, k=0, tw_conj=0, overriding Start, Ack, Stall.
REQ-033 After Reset, outputs are: Valid=0, Done=0, state=4'd0, i_top=0, i_bot=1, address=0, stage=0.
REQ-034 Reset asserted mid-PROC aborts the transform with no further Valid; a new Start is needed afterwards.

Verification
REQ-035 LOGN=3, Start pulse, Stall=0 -> 12 Valid cycles: s0 (0,1)(2,3)(4,5)(6,7) addr 0,0,0,0; s1 (0,2)(1,3)(4,6)(5,7) addr 0,2,0,2; s2 (0,4)(1,5)(2,6)(3,7) addr 0,1,2,3; then Done=1.
REQ-036 LOGN=3, Stall high for 3 cycles at k=2, s=1 -> pair (4,6) held with Valid=0 for those cycles, sequence resumes unchanged, total 15 PROC cycles.
REQ-037 LOGN=8, Inverse=1 at Start, toggled during PROC -> tw_conj=1 throughout; 1024 Valid cycles; last pair (127,255), address 127.
REQ-038 In DONE with Start=1 and Ack=1 in the same cycle -> INIT for one cycle, then PROC because Start is still high.
REQ-039 Reset=0 during LOGN=3 stage 1 -> next cycle state=0, Valid=0, i_top=0, i_bot=1; Start then restarts from s=0, k=0.
REQ-040 Scoreboard: run the consumer butterfly on the bit-reversed 8-point impulse x[0]=1 -> all X[k]=1; with Inverse=1, running the result back through -> N*x.

Source files
------------

// File: rtl/fft_addr_seq.sv
// Address sequencer for an in-place radix-2 DIT FFT: walks every butterfly of
// every stage, producing operand indices and twiddle ROM index one per cycle.
module fft_addr_seq #(
    parameter int LOGN = 8
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Ack,
    input  logic            Stall,
    input  logic            Inverse,
    output logic [LOGN-1:0] i_top,
    output logic [LOGN-1:0] i_bot,
    output logic [LOGN-2:0] address,
    output logic            Valid,
    output logic            tw_conj,
    output logic [3:0]      stage,
    output logic            Done,
    output logic [3:0]      state
);

    localparam logic [3:0]      INIT   = 4'd0;
    localparam logic [3:0]      DONE   = 4'd1;
    localparam logic [3:0]      PROC   = 4'd2;
    localparam logic [LOGN-2:0] K_LAST = '1;
    localparam logic [3:0]      S_LAST = 4'(LOGN - 1);

    logic [3:0]      state_reg, state_next;
    logic [3:0]      s_reg, s_next;
    logic [LOGN-2:0] k_reg, k_next;
    logic            conj_reg, conj_next;

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        k_next     = k_reg;
        conj_next  = conj_reg;
        case (state_reg)
            INIT: begin
                if (Start) begin
                    state_next = PROC;
                    s_next     = 4'd0;
                    k_next     = '0;
                    conj_next  = Inverse;
                end
            end
            PROC: begin
                if (!Stall) begin
                    if (k_reg != K_LAST) begin
                        k_next = k_reg + 1'b1;
                    end else if (s_reg != S_LAST) begin
                        // Next stage starts on the very next cycle, no bubble.
                        k_next = '0;
                        s_next = s_reg + 4'd1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (Ack) begin
                    state_next = INIT;
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_reg <= INIT;
            s_reg     <= 4'd0;
            k_reg     <= '0;
            conj_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            k_reg     <= k_next;
            conj_reg  <= conj_next;
        end
    end

    // half = 2^s as a one-hot, low_mask = half-1; both decoded bitwise from s.
    logic [LOGN-1:0] k_ext, half, low_mask, pos, grp_part;
    logic [3:0]      addr_sh;

    for (genvar gi = 0; gi < LOGN; gi++) begin : g_mask
        assign half[gi]     = (s_reg == 4'(gi));
        assign low_mask[gi] = (s_reg > 4'(gi));
    end

    always_comb begin
        k_ext    = {1'b0, k_reg};
        pos      = k_ext & low_mask;
        // grp*2*half is k with its low s bits cleared, shifted up once.
        grp_part = (k_ext & ~low_mask) << 1;
        addr_sh  = S_LAST - s_reg;
    end

    assign i_top   = grp_part | pos;
    assign i_bot   = i_top | half;
    assign address = pos[LOGN-2:0] << addr_sh;
    assign Valid   = (state_reg == PROC) && !Stall;
    assign Done    = (state_reg == DONE);
    assign tw_conj = conj_reg;
    assign stage   = s_reg;
    assign state   = state_reg;

endmodule

// File: tb/tb_fft_addr_seq.sv
// Bench for fft_addr_seq: LOGN=3 table/scoreboard runs with an FFT consumer
// model, control corner cases, and a full LOGN=8 inverse run.
module tb_fft_addr_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset3, start3, ack3, stall3, inv3;
    logic [2:0] top3, bot3;
    logic [1:0] addr3;
    logic       valid3, conj3, done3;
    logic [3:0] stage3, state3;

    logic       reset8, start8, ack8, stall8, inv8;
    logic [7:0] top8, bot8;
    logic [6:0] addr8;
    logic       valid8, conj8, done8;
    logic [3:0] stage8, state8;

    fft_addr_seq #(.LOGN(3)) dut3 (
        .Clk(clk), .Reset(reset3), .Start(start3), .Ack(ack3), .Stall(stall3),
        .Inverse(inv3), .i_top(top3), .i_bot(bot3), .address(addr3),
        .Valid(valid3), .tw_conj(conj3), .stage(stage3), .Done(done3),
        .state(state3)
    );

    fft_addr_seq #(.LOGN(8)) dut8 (
        .Clk(clk), .Reset(reset8), .Start(start8), .Ack(ack8), .Stall(stall8),
        .Inverse(inv8), .i_top(top8), .i_bot(bot8), .address(addr8),
        .Valid(valid8), .tw_conj(conj8), .stage(stage8), .Done(done8),
        .state(state8)
    );

    typedef struct {
        bit stall;
        bit valid;
        int top;
        int bot;
        int addr;
        int stg;
    } vec_t;

    typedef struct {
        int top;
        int bot;
        int addr;
    } bfly_t;

    vec_t  base_tbl[12];
    vec_t  run_tbl[$];
    bfly_t sb3[$];
    bfly_t sb8[$];
    int    tests = 0;
    int    fails = 0;
    real   re[8];
    real   im[8];
    bit    fft_on;
    bit    cur_inv;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_real(input string name, input real act, input real exp);
        tests++;
        if ((act - exp) > 1.0e-6 || (exp - act) > 1.0e-6) begin
            fails++;
            $display("FAIL %s: got %f expected %f", name, act, exp);
        end
    endtask

    task automatic cycle;
        @(posedge clk);
        #1;
    endtask

    // Consumer butterfly on the bench's own data, addressed by the DUT.
    task automatic butterfly(input int t, input int b, input int a, input bit cj);
        real ang, wr, wi, tr, ti;
        ang = 2.0 * 3.14159265358979 * a / 8.0;
        wr  = $cos(ang);
        wi  = cj ? $sin(ang) : -$sin(ang);
        tr  = re[b] * wr - im[b] * wi;
        ti  = re[b] * wi + im[b] * wr;
        re[b] = re[t] - tr;
        im[b] = im[t] - ti;
        re[t] = re[t] + tr;
        im[t] = im[t] + ti;
    endtask

    task automatic step3(input vec_t row, input string tag);
        bfly_t e;
        stall3 = row.stall;
        if (!row.stall) sb3.push_back('{row.top, row.bot, row.addr});
        @(negedge clk);
        chk({tag, " valid"}, int'(valid3), int'(row.valid));
        chk({tag, " state"}, int'(state3), 2);
        chk({tag, " stage"}, int'(stage3), row.stg);
        chk({tag, " tw_conj"}, int'(conj3), int'(cur_inv));
        if (valid3) begin
            chk({tag, " sb_nonempty"}, int'(sb3.size() > 0), 1);
            if (sb3.size() > 0) begin
                e = sb3.pop_front();
                chk({tag, " i_top"}, int'(top3), e.top);
                chk({tag, " i_bot"}, int'(bot3), e.bot);
                chk({tag, " address"}, int'(addr3), e.addr);
            end
            if (fft_on) butterfly(int'(top3), int'(bot3), int'(addr3), conj3);
        end else begin
            chk({tag, " held_top"}, int'(top3), row.top);
            chk({tag, " held_bot"}, int'(bot3), row.bot);
            chk({tag, " held_addr"}, int'(addr3), row.addr);
        end
        cycle();
    endtask

    // Runs one LOGN=3 transform and leaves the DUT in DONE.
    task automatic run3(input bit inverse, input int stall_idx, input int nstall,
                        input string tag);
        run_tbl.delete();
        for (int i = 0; i < 12; i++) begin
            if (i == stall_idx) begin
                for (int j = 0; j < nstall; j++) begin
                    vec_t v;
                    v       = base_tbl[i];
                    v.stall = 1'b1;
                    v.valid = 1'b0;
                    run_tbl.push_back(v);
                end
            end
            run_tbl.push_back(base_tbl[i]);
        end
        cur_inv = inverse;
        inv3    = inverse;
        start3  = 1'b1;
        cycle();
        start3  = 1'b0;
        foreach (run_tbl[i]) begin
            inv3 = 1'($urandom_range(0, 1));
            step3(run_tbl[i], $sformatf("%s[%0d]", tag, i));
        end
        stall3 = 1'b0;
        @(negedge clk);
        chk({tag, " done"}, int'(done3), 1);
        chk({tag, " done_state"}, int'(state3), 1);
        chk({tag, " done_valid"}, int'(valid3), 0);
        chk({tag, " sb_drained"}, int'(sb3.size()), 0);
        start3 = 1'b1;
        cycle();
        @(negedge clk);
        chk({tag, " start_ignored_in_done"}, int'(state3), 1);
        start3 = 1'b0;
        cycle();
    endtask

    task automatic ack3_to_init(input string tag);
        ack3 = 1'b1;
        cycle();
        ack3 = 1'b0;
        @(negedge clk);
        chk({tag, " ack_to_init"}, int'(state3), 0);
        cycle();
    endtask

    initial begin
        int tops[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
        int bots[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
        int addrs[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
        int cnt, last_top, last_bot, last_addr;
        bfly_t e;

        reset3 = 1'b0; start3 = 1'b0; ack3 = 1'b0; stall3 = 1'b0; inv3 = 1'b0;
        reset8 = 1'b0; start8 = 1'b0; ack8 = 1'b0; stall8 = 1'b0; inv8 = 1'b0;
        fft_on = 1'b0; cur_inv = 1'b0;
        for (int i = 0; i < 12; i++)
            base_tbl[i] = '{1'b0, 1'b1, tops[i], bots[i], addrs[i], i / 4};

        start3 = 1'b1; ack3 = 1'b1; stall3 = 1'b1;
        cycle();
        reset3 = 1'b1; reset8 = 1'b1;
        start3 = 1'b0; ack3 = 1'b0; stall3 = 1'b0;
        @(negedge clk);
        chk("rst valid", int'(valid3), 0);
        chk("rst done", int'(done3), 0);
        chk("rst state", int'(state3), 0);
        chk("rst i_top", int'(top3), 0);
        chk("rst i_bot", int'(bot3), 1);
        chk("rst address", int'(addr3), 0);
        chk("rst stage", int'(stage3), 0);
        chk("rst tw_conj", int'(conj3), 0);
        chk("rst8 i_bot", int'(bot8), 1);
        chk("rst8 state", int'(state8), 0);
        cycle();

        // Forward transform of the 8-point impulse: every bin is 1.
        for (int i = 0; i < 8; i++) begin re[i] = 0.0; im[i] = 0.0; end
        re[0]  = 1.0;
        fft_on = 1'b1;
        run3(1'b0, -1, 0, "fwd");
        for (int i = 0; i < 8; i++) begin
            chk_real($sformatf("fwd X%0d re", i), re[i], 1.0);
            chk_real($sformatf("fwd X%0d im", i), im[i], 0.0);
        end
        ack3_to_init("fwd");

        // All-ones spectrum is its own bit-reversal; inverse gives N*impulse.
        run3(1'b1, -1, 0, "inv");
        for (int i = 0; i < 8; i++) begin
            chk_real($sformatf("inv x%0d re", i), re[i], (i == 0) ? 8.0 : 0.0);
            chk_real($sformatf("inv x%0d im", i), im[i], 0.0);
        end
        ack3_to_init("inv");
        fft_on = 1'b0;

        run3(1'b0, 6, 3, "stall");

        // Start and Ack together in DONE: one INIT cycle, then PROC.
        start3 = 1'b1;
        ack3   = 1'b1;
        cycle();
        ack3 = 1'b0;
        @(negedge clk);
        chk("start_ack init_state", int'(state3), 0);
        chk("start_ack init_valid", int'(valid3), 0);
        cycle();
        start3 = 1'b0;
        @(negedge clk);
        chk("start_ack proc_state", int'(state3), 2);
        chk("start_ack proc_valid", int'(valid3), 1);
        chk("start_ack proc_top", int'(top3), 0);
        chk("start_ack proc_bot", int'(bot3), 1);
        for (int i = 0; i < 5; i++) cycle();
        @(negedge clk);
        chk("midrun stage", int'(stage3), 1);
        chk("midrun i_top", int'(top3), 1);
        chk("midrun i_bot", int'(bot3), 3);
        chk("midrun address", int'(addr3), 2);

        // Reset in stage 1 overrides a simultaneous Start.
        reset3 = 1'b0;
        start3 = 1'b1;
        cycle();
        reset3 = 1'b1;
        start3 = 1'b0;
        @(negedge clk);
        chk("midrst state", int'(state3), 0);
        chk("midrst valid", int'(valid3), 0);
        chk("midrst i_top", int'(top3), 0);
        chk("midrst i_bot", int'(bot3), 1);
        chk("midrst stage", int'(stage3), 0);
        cycle();
        @(negedge clk);
        chk("midrst no_restart", int'(state3), 0);
        start3 = 1'b1;
        cycle();
        start3 = 1'b0;
        @(negedge clk);
        chk("restart state", int'(state3), 2);
        chk("restart valid", int'(valid3), 1);
        chk("restart i_top", int'(top3), 0);
        chk("restart i_bot", int'(bot3), 1);
        chk("restart stage", int'(stage3), 0);

        // LOGN=8 inverse run with Inverse toggling during PROC.
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < 128; k++) begin
                int half, pos, grp;
                half = 1 << s;
                pos  = k % half;
                grp  = k / half;
                sb8.push_back('{grp * 2 * half + pos, grp * 2 * half + pos + half,
                                pos * (1 << (7 - s))});
            end
        end
        inv8   = 1'b1;
        start8 = 1'b1;
        cycle();
        start8 = 1'b0;
        cnt = 0; last_top = -1; last_bot = -1; last_addr = -1;
        for (int c = 0; c < 1100; c++) begin
            inv8 = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done8) break;
            if (valid8) begin
                cnt++;
                chk($sformatf("n256 conj[%0d]", cnt), int'(conj8), 1);
                if (sb8.size() > 0) begin
                    e = sb8.pop_front();
                    chk($sformatf("n256 i_top[%0d]", cnt), int'(top8), e.top);
                    chk($sformatf("n256 i_bot[%0d]", cnt), int'(bot8), e.bot);
                    chk($sformatf("n256 addr[%0d]", cnt), int'(addr8), e.addr);
                end
                last_top  = int'(top8);
                last_bot  = int'(bot8);
                last_addr = int'(addr8);
            end
            cycle();
        end
        chk("n256 done", int'(done8), 1);
        chk("n256 valid_count", cnt, 1024);
        chk("n256 sb_drained", int'(sb8.size()), 0);
        chk("n256 last_top", last_top, 127);
        chk("n256 last_bot", last_bot, 255);
        chk("n256 last_addr", last_addr, 127);
        chk("n256 done_conj", int'(conj8), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
